// File: rtl/blur_scheduler_if.sv
// Handshake bundle between the blur scheduler, the frame buffer (fetch/write-back) and the blur controller.
interface blur_scheduler_if #(
   parameter int COORD_BITS = 32
);
   logic                  fetch_req;
   logic                  fetch_ack;
   logic                  anchor_moving;
   logic [COORD_BITS-1:0] anchor_x;
   logic [COORD_BITS-1:0] anchor_y;
   logic                  blur_final;
   logic                  write_req;
   logic [COORD_BITS-1:0] write_y;
   logic                  write_ack;

   modport master (
      output fetch_req, anchor_moving, anchor_x, anchor_y, write_req, write_y,
      input  fetch_ack, blur_final, write_ack
   );

   modport slave (
      input  fetch_req, anchor_moving, anchor_x, anchor_y, write_req, write_y,
      output fetch_ack, blur_final, write_ack
   );
endinterface

// File: rtl/blur_scheduler.sv
// Blur-stage sequencer: walks the frame in vertical strips, row by row, fetch -> kick -> filter -> write-back.
// Optional blur_final watchdog enabled by defining BLUR_TIMEOUT_EN.
module blur_scheduler #(
   parameter int COORD_BITS     = 32,
   parameter int STRIP_WIDTH    = 16,
   parameter int WRITE_LAG      = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [COORD_BITS-1:0] image_width,
   input  logic [COORD_BITS-1:0] image_height,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  timeout_err,
   blur_scheduler_if.master      bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_KICK,
      S_FILTER,
      S_WRITE,
      S_ADVANCE
   } state_t;

   if (TIMEOUT_CYCLES < 1 || STRIP_WIDTH < 1 || WRITE_LAG < 0) begin : g_param_check
      $error("blur_scheduler: invalid parameter value");
   end

   state_t                state, state_nxt;
   logic [COORD_BITS-1:0] width_q, height_q;
   logic [COORD_BITS-1:0] ax_q, ay_q, wy_q;
   logic                  done_q;
   logic [COORD_BITS:0]   y_next, x_next;
   logic                  row_more, strip_more, zero_dims, write_due;
   logic                  timeout_hit;

   // One extra bit keeps the end-of-row/strip tests correct for dimensions near 2^COORD_BITS.
   assign y_next     = {1'b0, ay_q} + (COORD_BITS+1)'(1);
   assign x_next     = {1'b0, ax_q} + (COORD_BITS+1)'(STRIP_WIDTH);
   assign row_more   = y_next < {1'b0, height_q};
   assign strip_more = x_next < {1'b0, width_q};
   assign zero_dims  = (image_width == '0) || (image_height == '0);
   assign write_due  = ay_q >= COORD_BITS'(WRITE_LAG);

`ifdef BLUR_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] to_cnt;
   logic            to_err_q;

   assign timeout_hit = (state == S_FILTER) && !bus.blur_final
                        && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign timeout_err = to_err_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         to_cnt   <= '0;
         to_err_q <= 1'b0;
      end else begin
         if (state == S_KICK)
            to_cnt <= '0;
         else if (state == S_FILTER)
            to_cnt <= to_cnt + TO_W'(1);

         if (!abort) begin
            if (state == S_IDLE && start)
               to_err_q <= 1'b0;
            else if (timeout_hit)
               to_err_q <= 1'b1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (start && !zero_dims) state_nxt = S_FETCH;
         S_FETCH:   if (bus.fetch_ack) state_nxt = S_KICK;
         S_KICK:    state_nxt = S_FILTER;
         S_FILTER: begin
            if (bus.blur_final)
               state_nxt = write_due ? S_WRITE : S_ADVANCE;
            else if (timeout_hit)
               state_nxt = S_IDLE;
         end
         S_WRITE:   if (bus.write_ack) state_nxt = S_ADVANCE;
         S_ADVANCE: state_nxt = (row_more || strip_more) ? S_FETCH : S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
      if (abort)
         state_nxt = S_IDLE;
   end

   // Anchor registers freeze on abort so the aborted position stays observable.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         width_q  <= '0;
         height_q <= '0;
         ax_q     <= '0;
         ay_q     <= '0;
         wy_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (!abort) begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     width_q  <= image_width;
                     height_q <= image_height;
                     ax_q     <= '0;
                     ay_q     <= '0;
                     done_q   <= zero_dims;
                  end
               end
               S_FILTER: begin
                  if (bus.blur_final && write_due)
                     wy_q <= ay_q - COORD_BITS'(WRITE_LAG);
               end
               S_ADVANCE: begin
                  if (row_more) begin
                     ay_q <= y_next[COORD_BITS-1:0];
                  end else if (strip_more) begin
                     ax_q <= x_next[COORD_BITS-1:0];
                     ay_q <= '0;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.fetch_req     = (state == S_FETCH);
   assign bus.anchor_moving = (state == S_KICK);
   assign bus.write_req     = (state == S_WRITE);
   assign bus.anchor_x      = ax_q;
   assign bus.anchor_y      = ay_q;
   assign bus.write_y       = wy_q;
   assign busy              = (state != S_IDLE);
   assign frame_done        = done_q;

endmodule

// File: tb/tb_blur_scheduler.sv
// Randomized bench for blur_scheduler: responders with random latencies, a monitor logging handshakes,
// and a strip/row reference model built from nested loops.
module tb_blur_scheduler;
   localparam int CB  = 32;
   localparam int SW  = 16;
   localparam int LAG = 2;

   typedef struct packed {
      logic [CB-1:0] x;
      logic [CB-1:0] y;
   } pt_t;

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [CB-1:0] image_width = '0;
   logic [CB-1:0] image_height = '0;
   logic          busy, frame_done, timeout_err;

   blur_scheduler_if #(.COORD_BITS(CB)) bus ();

   blur_scheduler dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .start        (start),
      .abort        (abort),
      .image_width  (image_width),
      .image_height (image_height),
      .busy         (busy),
      .frame_done   (frame_done),
      .timeout_err  (timeout_err),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Responder configuration and logs
   int  fmin = 0, fmax = 0, wmin = 0, wmax = 0, bmin = 0, bmax = 0;
   bit  stray_en = 1'b0;
   bit  abort_arm = 1'b0, abort_fired = 1'b0;
   logic [CB-1:0] abort_x = '0, abort_y = '0;
   pt_t fetch_log[$], write_log[$], exp_fetch[$], exp_write[$];
   int  n_moves = 0, n_done = 0, writes_at_done = -1, freq_cycles = 0;
   int  flen_min = 1000, flen_max = 0;

   // Responder state (single process keeps drive/observe ordering deterministic)
   bit  f_act, w_act, b_pend, acked, prev_freq, prev_wreq;
   int  f_cnt, w_cnt, b_cnt, flen;
   logic [CB-1:0] px, py, pwy;
   pt_t p;

   always @(negedge clk) begin
      if (!n_rst) begin
         f_act = 0; w_act = 0; b_pend = 0; acked = 0; prev_freq = 0; prev_wreq = 0; flen = 0;
         bus.fetch_ack = 0; bus.write_ack = 0; bus.blur_final = 0; abort = 0;
      end else begin
         abort = 1'b0;
         if (bus.fetch_req) begin
            if (!f_act) begin f_act = 1; f_cnt = int'($urandom_range(fmax, fmin)); end
            if (f_cnt == 0) bus.fetch_ack = 1'b1;
            else begin bus.fetch_ack = 1'b0; f_cnt--; end
         end else begin
            f_act = 0;
            bus.fetch_ack = stray_en && ($urandom_range(3, 0) == 0);
         end
         if (bus.write_req) begin
            if (!w_act) begin w_act = 1; w_cnt = int'($urandom_range(wmax, wmin)); end
            if (w_cnt == 0) bus.write_ack = 1'b1;
            else begin bus.write_ack = 1'b0; w_cnt--; end
         end else begin
            w_act = 0;
            bus.write_ack = stray_en && ($urandom_range(3, 0) == 0);
         end
         bus.blur_final = 1'b0;
         if (b_pend) begin
            if (b_cnt == 0) begin
               bus.blur_final = 1'b1;
               b_pend = 0;
               if (abort_arm && bus.anchor_x == abort_x && bus.anchor_y == abort_y) begin
                  abort = 1'b1; abort_arm = 0; abort_fired = 1;
               end
            end else b_cnt--;
         end
         if (bus.anchor_moving && !b_pend) begin
            b_pend = 1; b_cnt = int'($urandom_range(bmax, bmin));
         end

         // Monitor: the acks above are what the DUT samples on the coming edge
         if (bus.fetch_req) begin
            freq_cycles++;
            if (prev_freq) begin
               check("fetch_x_stable", bus.anchor_x, px);
               check("fetch_y_stable", bus.anchor_y, py);
            end
            flen++;
            if (bus.fetch_ack) begin
               p.x = bus.anchor_x; p.y = bus.anchor_y;
               fetch_log.push_back(p);
               if (flen < flen_min) flen_min = flen;
               if (flen > flen_max) flen_max = flen;
               flen = 0; acked = 1;
            end
         end else flen = 0;
         prev_freq = bus.fetch_req; px = bus.anchor_x; py = bus.anchor_y;
         if (bus.anchor_moving) begin
            n_moves++;
            check("move_after_ack", acked, 1);
            acked = 0;
         end
         if (bus.write_req) begin
            if (prev_wreq) check("write_y_stable", bus.write_y, pwy);
            if (bus.write_ack) begin
               p.x = bus.anchor_x; p.y = bus.write_y;
               write_log.push_back(p);
            end
         end
         prev_wreq = bus.write_req; pwy = bus.write_y;
         if (frame_done) begin n_done++; writes_at_done = write_log.size(); end
      end
   end

   task automatic build_expect(input int w, input int h);
      pt_t e;
      exp_fetch.delete(); exp_write.delete();
      for (longint x = 0; x < w; x += SW)
         for (int y = 0; y < h; y++) begin
            e.x = CB'(x); e.y = CB'(y);
            exp_fetch.push_back(e);
            if (y >= LAG) begin e.y = CB'(y - LAG); exp_write.push_back(e); end
         end
   endtask

   task automatic clear_logs();
      fetch_log.delete(); write_log.delete();
      n_moves = 0; n_done = 0; writes_at_done = -1; freq_cycles = 0;
      flen_min = 1000; flen_max = 0;
   endtask

   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic run_frame(input int w, input int h);
      int cyc;
      clear_logs();
      build_expect(w, h);
      image_width = CB'(w); image_height = CB'(h); start = 1;
      step(); start = 0; image_width = $urandom; image_height = $urandom;
      step(); start = 1;
      step(); start = 0;
      cyc = 0;
      while (n_done == 0 && cyc < 4000) begin step(); cyc++; end
      check($sformatf("done_%0dx%0d", w, h), n_done, 1);
      step();
      check("done_once", n_done, 1);
      check("idle_after_frame", busy, 0);
      check("done_is_pulse", frame_done, 0);
      check("n_moves", n_moves, exp_fetch.size());
      check("done_after_last_write", writes_at_done, exp_write.size());
      check("n_fetch", fetch_log.size(), exp_fetch.size());
      for (int i = 0; i < exp_fetch.size() && i < fetch_log.size(); i++) begin
         check($sformatf("fetch%0d_x", i), fetch_log[i].x, exp_fetch[i].x);
         check($sformatf("fetch%0d_y", i), fetch_log[i].y, exp_fetch[i].y);
      end
      check("n_write", write_log.size(), exp_write.size());
      for (int i = 0; i < exp_write.size() && i < write_log.size(); i++) begin
         check($sformatf("write%0d_x", i), write_log[i].x, exp_write[i].x);
         check($sformatf("write%0d_y", i), write_log[i].y, exp_write[i].y);
      end
   endtask

   task automatic zero_frame(input int w, input int h);
      bit busy_seen;
      clear_logs();
      image_width = CB'(w); image_height = CB'(h); start = 1;
      step(); start = 0; busy_seen = busy;
      step(); busy_seen |= busy;
      check("zero_done_2cyc", n_done, 1);
      repeat (3) begin step(); busy_seen |= busy; end
      check("zero_done_once", n_done, 1);
      check("zero_busy", busy_seen, 0);
      check("zero_no_fetch", freq_cycles, 0);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc;
      repeat (2) @(posedge clk);
      #1;
      check("rst_fetch_req", bus.fetch_req, 0);
      check("rst_write_req", bus.write_req, 0);
      check("rst_anchor_moving", bus.anchor_moving, 0);
      check("rst_anchor_x", bus.anchor_x, 0);
      check("rst_anchor_y", bus.anchor_y, 0);
      check("rst_write_y", bus.write_y, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_timeout_err", timeout_err, 0);
      step(); n_rst = 1;
      step();

      run_frame(32, 3);
      run_frame(20, 4);
      zero_frame(0, 5);
      zero_frame(7, 0);

      fmin = 5; fmax = 5;
      run_frame(16, 2);
      check("fetch_len_min", flen_min, 6);
      check("fetch_len_max", flen_max, 6);
      fmin = 0; fmax = 0;

      // Abort together with blur_final at (16,1)
      clear_logs();
      abort_x = 16; abort_y = 1; abort_fired = 0; abort_arm = 1;
      image_width = 32; image_height = 3; start = 1;
      step(); start = 0;
      cyc = 0;
      while (!abort_fired && cyc < 500) begin step(); cyc++; end
      check("abort_reached", abort_fired, 1);
      check("abort_idle", busy, 0);
      check("abort_no_write_req", bus.write_req, 0);
      check("abort_no_fetch_req", bus.fetch_req, 0);
      repeat (8) step();
      check("abort_no_done", n_done, 0);
      check("abort_writes", write_log.size(), 1);
      check("abort_fetches", fetch_log.size(), 5);
      check("abort_hold_x", bus.anchor_x, 16);
      check("abort_hold_y", bus.anchor_y, 1);
      abort_arm = 0;
      run_frame(32, 3);

      // Asynchronous reset in the middle of a frame
      image_width = 48; image_height = 4; start = 1;
      step(); start = 0;
      cyc = 0;
      while (bus.anchor_x != 32 && cyc < 500) begin step(); cyc++; end
      check("midrst_reached", bus.anchor_x, 32);
      n_rst = 0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_anchor_x", bus.anchor_x, 0);
      check("midrst_anchor_y", bus.anchor_y, 0);
      check("midrst_write_y", bus.write_y, 0);
      check("midrst_fetch_req", bus.fetch_req, 0);
      check("midrst_write_req", bus.write_req, 0);
      step(); n_rst = 1;
      step();

      stray_en = 1;
      for (int i = 0; i < 10; i++) begin
         fmax = int'($urandom_range(3, 0));
         wmax = int'($urandom_range(3, 0));
         bmax = int'($urandom_range(3, 0));
         run_frame(int'($urandom_range(70, 1)), int'($urandom_range(6, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
